// File: rtl/clint_pkg.sv
// Core-local interruptor shared definitions: register offsets, request struct,
// address decode and byte-lane merge helpers.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_MT_LO,
    SEL_MT_HI
  } reg_sel_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [13:0] word;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  // Decode on the word address; byte offset bits are dropped by the caller.
  function automatic reg_sel_t decode(input logic [13:0] word);
    reg_sel_t sel;
    sel = SEL_NONE;
    if (word == CLINT_MSIP[15:2])        sel = SEL_MSIP;
    if (word == CLINT_MTIMECMP_LO[15:2]) sel = SEL_CMP_LO;
    if (word == CLINT_MTIMECMP_HI[15:2]) sel = SEL_CMP_HI;
    if (word == CLINT_MTIME_LO[15:2])    sel = SEL_MT_LO;
    if (word == CLINT_MTIME_HI[15:2])    sel = SEL_MT_HI;
    return sel;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// mtime prescaler: counts 0..TICK_DIV-1 and pulses tick on the wrap cycle.
module clint_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt;

  // With TICK_DIV=1 the counter sits at 0 and tick is held high.
  assign tick = (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip, 64-bit mtime/mtimecmp, timer and software
// interrupt requests behind a single-cycle-accept register bus.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bus_valid,
  input  logic        bus_write,
  input  logic [15:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic        bus_ready,
  output logic        bus_rvalid,
  output logic [31:0] bus_rdata,
  output logic        timer_int,
  output logic        soft_int
);

  bus_req_t    req;
  reg_sel_t    sel;
  logic        wr, rd, tick;
  logic        msip;
  logic [63:0] mtime, mtime_nxt;
  logic [63:0] mtimecmp, cmp_nxt;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  assign req = '{valid: bus_valid, write: bus_write, word: bus_addr[15:2],
                 wdata: bus_wdata, wstrb: bus_wstrb};
  assign unused_addr_bits = ^bus_addr[1:0];

  assign sel = decode(req.word);
  assign wr  = req.valid & req.write;
  assign rd  = req.valid & ~req.write;

  assign bus_ready = ~reset;
  assign soft_int  = msip;

  clint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Any mtime write suppresses the tick for both words, so software can
  // load a value without racing the increment.
  always_comb begin
    mtime_nxt = mtime;
    cmp_nxt   = mtimecmp;
    if (wr && sel == SEL_MT_LO)
      mtime_nxt[31:0] = merge_bytes(mtime[31:0], req.wdata, req.wstrb);
    else if (wr && sel == SEL_MT_HI)
      mtime_nxt[63:32] = merge_bytes(mtime[63:32], req.wdata, req.wstrb);
    else if (tick)
      mtime_nxt = mtime + 64'd1;
    if (wr && sel == SEL_CMP_LO)
      cmp_nxt[31:0] = merge_bytes(mtimecmp[31:0], req.wdata, req.wstrb);
    if (wr && sel == SEL_CMP_HI)
      cmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], req.wdata, req.wstrb);
  end

  always_comb begin
    rd_word = '0;
    case (sel)
      SEL_MSIP:   rd_word = {31'd0, msip};
      SEL_CMP_LO: rd_word = mtimecmp[31:0];
      SEL_CMP_HI: rd_word = mtimecmp[63:32];
      SEL_MT_LO:  rd_word = mtime[31:0];
      SEL_MT_HI:  rd_word = mtime[63:32];
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      timer_int  <= 1'b0;
      bus_rvalid <= 1'b0;
      bus_rdata  <= '0;
    end else begin
      mtime      <= mtime_nxt;
      mtimecmp   <= cmp_nxt;
      if (wr && sel == SEL_MSIP && req.wstrb[0]) msip <= req.wdata[0];
      timer_int  <= (mtime >= mtimecmp);
      bus_rvalid <= rd;
      if (rd) bus_rdata <= rd_word;
    end
  end

endmodule
